// File: rtl/spart_pkg.sv
// Shared SPART definitions: receiver state type, oversampling defaults and bus register map.
package spart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

    localparam int OVERSAMPLE_DEF = 16;
    localparam int MID_TICK_DEF   = 8;

    localparam logic [1:0] ADDR_DATA   = 2'b00;
    localparam logic [1:0] ADDR_STATUS = 2'b01;
    localparam logic [1:0] ADDR_DBL    = 2'b10;
    localparam logic [1:0] ADDR_DBH    = 2'b11;

endpackage

// File: rtl/spart_rx_sync.sv
// Two-flop synchronizer for the serial line plus a 1->0 edge detector on the synchronized value.
module rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rxd,
    output logic rxs,
    output logic fall
);

    logic s1, s2, s3;

    // All stages reset to the idle-high line level so reset never fakes a start edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            s1 <= rxd;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rxs  = s2;
    assign fall = s3 & ~s2;

endmodule

// File: rtl/spart_rx.sv
// SPART receiver: oversampled 8N1 deframer with data-available, framing-error and overrun flags.
// Handshake: a data read is the single cycle with ioaddr==ADDR_DATA and iorw=1; it clears rda/oe on the next edge.
module spart_rx
    import spart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int MID_TICK   = MID_TICK_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       rxd,
    input  logic [1:0] ioaddr,
    input  logic       iorw,
    output logic [7:0] rx_data,
    output logic       rda,
    output logic       ferr,
    output logic       oe,
    output rx_state_e  dbg_state
);

    localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] MID_LAST  = 4'(MID_TICK - 1);

    rx_state_e  state, next_state;
    logic [3:0] tick_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic       rxs, fall, rd;
    logic       sample, stop_ok, stop_err;
    logic       done_ok, done_err;

    rx_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .rxd  (rxd),
        .rxs  (rxs),
        .fall (fall)
    );

    assign rd        = (ioaddr == ADDR_DATA) && iorw;
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (fall) next_state = START;
            START: if (enable && tick_cnt == MID_LAST) next_state = rxs ? IDLE : DATA;
            DATA:  if (enable && tick_cnt == LAST_TICK && bit_cnt == 3'd7) next_state = STOP;
            STOP:  if (enable && tick_cnt == LAST_TICK) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        sample   = 1'b0;
        stop_ok  = 1'b0;
        stop_err = 1'b0;
        case (state)
            DATA: sample = enable && (tick_cnt == LAST_TICK);
            STOP: begin
                stop_ok  = enable && (tick_cnt == LAST_TICK) && rxs;
                stop_err = enable && (tick_cnt == LAST_TICK) && !rxs;
            end
            default: ;
        endcase
    end

    // Counters restart on every state change and otherwise only move on enable ticks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt <= 4'd0;
            bit_cnt  <= 3'd0;
            shreg    <= 8'h00;
            done_ok  <= 1'b0;
            done_err <= 1'b0;
        end else begin
            done_ok  <= stop_ok;
            done_err <= stop_err;
            if (sample) shreg <= {rxs, shreg[7:1]};
            if (state != next_state) begin
                tick_cnt <= 4'd0;
                bit_cnt  <= 3'd0;
            end else if (enable && state != IDLE) begin
                if (sample) begin
                    tick_cnt <= 4'd0;
                    bit_cnt  <= bit_cnt + 3'd1;
                end else begin
                    tick_cnt <= tick_cnt + 4'd1;
                end
            end
        end
    end

    // Flags follow the stop-bit decision by one clock; a completing byte beats a coincident read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_data <= 8'h00;
            rda     <= 1'b0;
            ferr    <= 1'b0;
            oe      <= 1'b0;
        end else if (done_ok) begin
            rx_data <= shreg;
            rda     <= 1'b1;
            ferr    <= 1'b0;
            oe      <= rd ? 1'b0 : (oe | rda);
        end else if (done_err) begin
            ferr <= 1'b1;
            if (rd) begin
                rda <= 1'b0;
                oe  <= 1'b0;
            end
        end else if (rd) begin
            rda <= 1'b0;
            oe  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spart_rx.sv
// Directed plus randomized frames against a frame-level model of the receiver flags and data.
module tb_spart_rx;
    import spart_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b0;
    logic       rxd = 1'b1;
    logic [1:0] ioaddr = 2'b01;
    logic       iorw = 1'b0;
    logic [7:0] rx_data;
    logic       rda, ferr, oe;
    rx_state_e  dbg_state;

    int vectors = 0;
    int miscompares = 0;
    int ecnt = 0;

    logic [7:0] exp_q[$];
    logic       m_rda = 1'b0, m_ferr = 1'b0, m_oe = 1'b0;

    spart_rx dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .rxd       (rxd),
        .ioaddr    (ioaddr),
        .iorw      (iorw),
        .rx_data   (rx_data),
        .rda       (rda),
        .ferr      (ferr),
        .oe        (oe),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // Baud tick: one clk wide, every 4 clocks, changed away from the rising edge.
    always @(negedge clk) begin
        enable = (ecnt == 3);
        ecnt = (ecnt + 1) % 4;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_data();
        return (exp_q.size() == 0) ? 8'h00 : exp_q[$];
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".rx_data"}, rx_data, exp_data());
        chk({tag, ".rda"}, {7'd0, rda}, {7'd0, m_rda});
        chk({tag, ".ferr"}, {7'd0, ferr}, {7'd0, m_ferr});
        chk({tag, ".oe"}, {7'd0, oe}, {7'd0, m_oe});
        chk({tag, ".state"}, 8'(dbg_state), 8'(IDLE));
    endtask

    // Frame-level rules: good stop loads data; bad stop only flags; a read racing completion loses to set.
    task automatic model_frame(input logic [7:0] b, input bit stop, input bit rd_now);
        if (stop) begin
            exp_q.push_back(b);
            m_ferr = 1'b0;
            m_oe = rd_now ? 1'b0 : (m_oe | m_rda);
            m_rda = 1'b1;
        end else begin
            m_ferr = 1'b1;
            if (rd_now) begin
                m_rda = 1'b0;
                m_oe = 1'b0;
            end
        end
    endtask

    // Called at a falling edge; start bit 0, 8 data bits LSB first, stop bit, 16 enables per bit.
    task automatic send_frame(input logic [7:0] b, input bit stop, input bit rd_at_done);
        logic [9:0] bits;
        int n;
        bits = {stop, b, 1'b0};
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    rxd = bits[i];
                    repeat (64) @(negedge clk);
                end
                rxd = 1'b1;
                repeat (48) @(negedge clk);
            end
            begin
                if (rd_at_done) begin
                    // Edge seen after 2 sync stages + detector, then 8 + 8*16 + 16 enables to the stop decision.
                    n = 0;
                    repeat (3) @(posedge clk);
                    while (n < 152) begin
                        @(posedge clk);
                        if (enable) n++;
                    end
                    @(negedge clk);
                    ioaddr = 2'b00;
                    iorw = 1'b1;
                    @(negedge clk);
                    ioaddr = 2'b01;
                    iorw = 1'b1;
                end
            end
        join
        model_frame(b, stop, rd_at_done);
    endtask

    task automatic do_read();
        ioaddr = 2'b00;
        iorw = 1'b1;
        @(negedge clk);
        ioaddr = 2'b01;
        iorw = 1'b0;
        m_rda = 1'b0;
        m_oe = 1'b0;
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_rda = 1'b0;
        m_ferr = 1'b0;
        m_oe = 1'b0;
    endtask

    initial begin
        logic [7:0] b;
        bit stop, rdc;

        #1;
        check_all("reset");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (8) @(negedge clk);

        // Short low pulse never reaches the mid-start check.
        rxd = 1'b0;
        repeat (20) @(negedge clk);
        rxd = 1'b1;
        repeat (200) @(negedge clk);
        check_all("false_start");

        send_frame(8'hA3, 1'b0, 1'b0);
        check_all("ferr_a3");

        send_frame(8'h55, 1'b1, 1'b0);
        check_all("good_55");

        // Writes and non-data addresses must not disturb the flags.
        ioaddr = 2'b00;
        iorw = 1'b0;
        repeat (2) @(negedge clk);
        ioaddr = 2'b10;
        iorw = 1'b1;
        repeat (2) @(negedge clk);
        ioaddr = 2'b01;
        check_all("no_read");
        do_read();
        check_all("read_55");

        send_frame(8'h12, 1'b1, 1'b0);
        send_frame(8'h34, 1'b1, 1'b0);
        check_all("overrun_34");
        do_read();
        check_all("read_34");

        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h7E, 1'b1, 1'b1);
        check_all("rd_race_7e");

        // Abort partway through bit 4 of a frame.
        rxd = 1'b0;
        repeat (64 + 4 * 64 + 30) @(negedge clk);
        #2;
        rst = 1'b0;
        rxd = 1'b1;
        model_reset();
        #1;
        check_all("async_reset");
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (8) @(negedge clk);
        send_frame(8'hC9, 1'b1, 1'b0);
        check_all("after_reset_c9");

        for (int k = 0; k < 10; k++) begin
            b = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            rdc = ($urandom_range(0, 3) == 0);
            ioaddr = 2'($urandom_range(1, 3));
            iorw = 1'($urandom_range(0, 1));
            @(negedge clk);
            send_frame(b, stop, rdc);
            check_all($sformatf("rand%0d", k));
            if ($urandom_range(0, 2) == 0) begin
                do_read();
                check_all($sformatf("rand_read%0d", k));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
